// File: rtl/ks_pkg.sv
// Shared constants and types for the Karplus-Strong string bank and its mixer.
package ks_pkg;
    localparam int          OUT_W      = 24;
    localparam int          GAIN_W     = 8;
    localparam int          PAGE_W     = 23;
    localparam int          REG_W      = 9;
    localparam logic [22:0] CTRL_SEL   = 23'h7FFFFF;

    localparam logic [8:0]  REG_MASTER = 9'h100;
    localparam logic [8:0]  REG_MUTE   = 9'h101;
    localparam logic [8:0]  REG_CLR    = 9'h102;

    typedef logic signed [OUT_W-1:0] sample_t;

    function automatic logic [PAGE_W-1:0] msg_page(input logic [31:0] addr);
        return addr[31:REG_W];
    endfunction

    function automatic logic [REG_W-1:0] msg_reg(input logic [31:0] addr);
        return addr[REG_W-1:0];
    endfunction
endpackage

// File: rtl/ks_mixer_bank_if.sv
// Message bus: one write strobe per sample, page/register address and data.
interface ks_mixer_bank_if;
    logic        msg_en;
    logic [31:0] msg_addr;
    logic [31:0] msg;

    modport master (output msg_en, msg_addr, msg);
    modport slave  (input  msg_en, msg_addr, msg);
endinterface

// File: rtl/ks_sat.sv
// Signed saturator: narrows IN_W to OUT_W, clamping to the OUT_W range and flagging a clip.
module ks_sat #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        dout = din[OUT_W-1:0];
        clip = 1'b0;
        if (din > MAX_V) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
            clip = 1'b1;
        end else if (din < MIN_V) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
            clip = 1'b1;
        end
    end
endmodule

// File: rtl/ks_wrap.sv
// Single string voice: register 0 loads the level, register 1 enables feedback
// accumulation of the mixed output (in >>> 4) with saturation.
module ks_wrap
    import ks_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_en,
    input  logic [8:0]  msg_addr,
    input  logic [31:0] msg,
    input  sample_t     in,
    output sample_t     out,
    output logic        overflow
);
    localparam int         W1        = OUT_W + 1;
    localparam logic [8:0] REG_LEVEL = 9'h000;
    localparam logic [8:0] REG_FB    = 9'h001;

    sample_t               level_q;
    sample_t               level_fb;
    logic                  fb_q;
    logic                  ovf_q;
    logic                  fb_clip;
    logic signed [W1-1:0]  fb_sum;
    logic                  unused_msg_hi;

    assign unused_msg_hi = ^msg[31:OUT_W];
    assign fb_sum        = W1'(level_q) + W1'(in >>> 4);

    ks_sat #(.IN_W(W1), .OUT_W(OUT_W)) u_sat (
        .din  (fb_sum),
        .dout (level_fb),
        .clip (fb_clip)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
            fb_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (msg_en && msg_addr == REG_LEVEL) begin
            level_q <= msg[OUT_W-1:0];
            ovf_q   <= 1'b0;
        end else if (msg_en && msg_addr == REG_FB) begin
            fb_q <= msg[0];
        end else if (fb_q) begin
            level_q <= level_fb;
            ovf_q   <= fb_clip;
        end
    end

    assign out      = level_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/ks_mixer_bank.sv
// Multi-string voice bank: per-string gain/mute, exact summation, master gain and
// saturation over a 3-stage pipeline, with a sticky clip flag cleared over the bus.
module ks_mixer_bank #(
    parameter int          N_STRINGS = 6,
    parameter int          GAIN_W    = ks_pkg::GAIN_W,
    parameter logic [22:0] CTRL_SEL  = ks_pkg::CTRL_SEL
) (
    input  logic              lrck,
    input  logic              rst,
    ks_mixer_bank_if.slave    bus,
    output ks_pkg::sample_t   out,
    output logic              overflow
);
    import ks_pkg::*;

    localparam int P_W    = OUT_W + 1;
    localparam int SUM_W  = OUT_W + 1 + $clog2(N_STRINGS);
    localparam int PROD_W = OUT_W + GAIN_W + 1;
    localparam int M_W    = SUM_W + GAIN_W + 1;
    localparam int MUTE_W = (N_STRINGS < 32) ? N_STRINGS : 32;
    localparam logic [GAIN_W-1:0] UNITY = {1'b1, {(GAIN_W-1){1'b0}}};

    logic [PAGE_W-1:0]       page;
    logic [REG_W-1:0]        idx;
    logic                    ctrl_wr;
    logic                    clr;

    sample_t                 str_out [N_STRINGS];
    logic [N_STRINGS-1:0]    str_ovf;

    logic [GAIN_W-1:0]       gain_q [N_STRINGS];
    logic [GAIN_W-1:0]       master_q;
    logic [N_STRINGS-1:0]    mute_q;
    logic                    sticky_q;

    logic signed [P_W-1:0]   p_d [N_STRINGS];
    logic signed [P_W-1:0]   p_q [N_STRINGS];
    logic                    so1_q;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic                    so2_q;
    logic signed [M_W-1:0]   m_prod;
    logic signed [M_W-1:0]   m_d;
    sample_t                 out_d;
    sample_t                 out_q;
    logic                    clip;
    logic                    ovf_q;

    assign page    = msg_page(bus.msg_addr);
    assign idx     = msg_reg(bus.msg_addr);
    assign ctrl_wr = bus.msg_en && (page == CTRL_SEL);
    assign clr     = ctrl_wr && (idx == REG_CLR) && bus.msg[0];

    // Each string sees only its own page; everything else is held at zero.
    for (genvar i = 0; i < N_STRINGS; i++) begin : g_str
        logic                              sel;
        logic signed [PROD_W-1:0]          prod;

        assign sel = (page == PAGE_W'(i));

        ks_wrap u_str (
            .clk      (lrck),
            .rst_n    (~rst),
            .msg_en   (bus.msg_en & sel),
            .msg_addr (sel ? idx : '0),
            .msg      (sel ? bus.msg : '0),
            .in       (out_q),
            .out      (str_out[i]),
            .overflow (str_ovf[i])
        );

        assign prod   = PROD_W'(str_out[i]) * PROD_W'($signed({1'b0, gain_q[i]}));
        assign p_d[i] = mute_q[i] ? '0 : P_W'(prod >>> (GAIN_W-1));
    end

    always_ff @(posedge lrck) begin
        if (rst) begin
            for (int i = 0; i < N_STRINGS; i++) gain_q[i] <= UNITY;
            master_q <= UNITY;
            mute_q   <= '0;
        end else if (ctrl_wr) begin
            for (int i = 0; i < N_STRINGS; i++) begin
                if (idx == REG_W'(i)) gain_q[i] <= bus.msg[GAIN_W-1:0];
            end
            if (idx == REG_MASTER) master_q <= bus.msg[GAIN_W-1:0];
            if (idx == REG_MUTE)   mute_q   <= N_STRINGS'(bus.msg[MUTE_W-1:0]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_STRINGS; i++) sum_d = sum_d + SUM_W'(p_q[i]);
    end

    assign m_prod = M_W'(sum_q) * M_W'($signed({1'b0, master_q}));
    assign m_d    = m_prod >>> (GAIN_W-1);

    ks_sat #(.IN_W(M_W), .OUT_W(OUT_W)) u_sat (
        .din  (m_d),
        .dout (out_d),
        .clip (clip)
    );

    always_ff @(posedge lrck) begin
        if (rst) begin
            p_q      <= '{default: '0};
            so1_q    <= 1'b0;
            sum_q    <= '0;
            so2_q    <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            p_q      <= p_d;
            so1_q    <= |str_ovf;
            sum_q    <= sum_d;
            so2_q    <= so1_q;
            out_q    <= out_d;
            ovf_q    <= clip | sticky_q | so2_q;
            // A clip on the same edge as a clear keeps the flag set.
            sticky_q <= clip ? 1'b1 : (clr ? 1'b0 : sticky_q);
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;
endmodule
